decode_issue: RTL and testbench
===============================

# decode_issue

Decode/issue stage sitting directly upstream of `alu_reg`. It accepts 32-bit RV32I instructions over a valid/ready handshake and decodes R-type, I-type ALU and LUI formats. It reads operands from an internal 32×32 register file and presents a registered `a`/`b`/`opcode` bundle to the ALU. A per-register scoreboard stalls issue on RAW/WAW hazards until the matching writeback returns.

## Interface
Parameters:
- `XLEN`, 32, datapath and register width.
- `NREGS`, 32, architectural register count; x0 is hardwired to zero.

Ports:
- `clk` in 1: single clock, all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: instruction present.
- `in_ready` out 1: stage accepts this cycle.
- `in_instr` in 32: raw instruction word.
- `out_valid` out 1: ALU bundle valid.
- `out_ready` in 1: ALU/downstream consumes the bundle.
- `out_a` out XLEN: ALU operand a.
- `out_b` out XLEN: ALU operand b.
- `out_opcode` out 7: instr[6:0].
- `out_funct3` out 3: instr[14:12].
- `out_funct7` out 7: instr[31:25]; forced 0 for non-R-type.
- `out_rd` out 5: destination register; 0 if no writeback.
- `out_illegal` out 1: unsupported opcode.
- `wb_valid` in 1: writeback strobe.
- `wb_rd` in 5: writeback destination.
- `wb_data` in XLEN: writeback value.

## Operation
- Opcodes handled:
  - R-type 0110011: a=rs1, b=rs2, uses rs1 and rs2.
  - I-type 0010011: a=rs1, b=sign-extended instr[31:20], uses rs1.
  - LUI 0110111: a=0, b={instr[31:12],12'b0}, uses no sources.
- Any other opcode: `out_illegal`=1, a=b=0, `out_rd`=0. No hazard check; passes through the handshake normally.
- Hazard `stall`:
  - A used rs (≠0) is busy and not bypassed this cycle, or
  - rd (≠0) is busy (WAW) and not cleared this cycle.
- `in_ready` = (!out_valid | out_ready) & !stall. Accept = in_valid & in_ready.
- Scoreboard `busy[31:0]`:
  - On accept with rd≠0, set busy[rd].
  - On wb_valid with wb_rd≠0, clear busy[wb_rd] and write wb_data into the register file.
  - Same-cycle set and clear of the same index: set wins, and the RF write still happens.
- Writeback bypass: if wb_valid and wb_rd equals a used rs≠0, the operand takes wb_data. That rs is not treated as busy this cycle.
- Writes to x0 are ignored; reads of x0 return 0.
- Output register:
  - Loaded on accept.
  - On out_valid & out_ready with no accept, out_valid clears.
  - Holds stable while out_valid & !out_ready.

## Timing
- Latency: instruction accepted at edge N; bundle visible with out_valid=1 after edge N. Throughput is 1 per cycle with no hazards and out_ready=1.
- RF write is visible to reads in the cycle after wb_valid, and to same-cycle reads via the bypass.
- Reset values: out_valid=0; out_a, out_b, out_opcode, out_funct3, out_funct7, out_rd=0; out_illegal=0; busy=0; all registers=0. in_ready is combinational and reads 1 after reset while in_valid has no hazard.
- Reset mid-operation drops the held bundle and all pending busy bits. Writebacks arriving in the reset cycle are discarded.
- Stalls never corrupt a held bundle. in_instr need not be held stable while not accepted, though upstream convention is to hold it.

## Structure
- Shared package/header `rv_defs`: opcode constants (OP_R, OP_IMM, OP_LUI), field-slice macros, XLEN.
- One sub-module, `gpr_file`: 2 async read ports, 1 sync write port, x0 read as 0, synchronous reset clear.
- Top contains the decode logic, the immediate generator, the scoreboard and the output register.

## Test plan
- Reset, then wb x1=FF00FF00 and x2=00FF00FF, then ADD x3,x1,x2 (0x002081B3). Expect one cycle later: out_a=FF00FF00, out_b=00FF00FF, out_opcode=0110011, out_rd=3, busy[3]=1.
- ADDI x4,x0,-1 (0xFFF00213). Expect out_a=0, out_b=FFFFFFFF, out_funct7=0.
- ADD x3,… issued, then ADD x5,x3,x3 presented. Expect in_ready=0 until wb_valid with wb_rd=3 and wb_data=12345678 arrives. In that cycle: accept, out_a=out_b=12345678 via bypass.
- Hold out_ready=0 for 3 cycles with a bundle valid. Expect the bundle stable and in_ready=0; release, and the next instruction is accepted the same cycle.
- LUI x6,0xABCDE (0xABCDE337). Expect out_b=ABCDE000, out_a=0. Opcode 0x0000007F gives out_illegal=1, out_rd=0, and busy unchanged.
- Assert rst while busy[3]=1 and out_valid=1. Expect out_valid=0, busy=0, and the next ADD reading x3 to issue with out_a=0.

Source files
------------

// File: rtl/decode_issue_pkg.sv
// rv_defs: shared RV32I decode definitions (XLEN, opcode constants, instruction kind)
package rv_defs;
  localparam int XLEN = 32;
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  typedef enum logic [1:0] {K_ILL, K_R, K_IMM, K_LUI} kind_e;
  function automatic kind_e kind_of(input logic [6:0] op);
    return op == OP_R ? K_R : op == OP_IMM ? K_IMM : op == OP_LUI ? K_LUI : K_ILL;
  endfunction
endpackage

// File: rtl/decode_issue_gpr_file.sv
// gpr_file: register file, 2 async read ports, 1 sync write port, x0 reads 0, sync reset clear
//   i_ra1/i_ra2 -> o_rd1/o_rd2 : combinational reads
//   i_we/i_wa/i_wd             : write on rising clk, writes to x0 dropped
module gpr_file #(
  parameter int XLEN = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      i_ra1,
  input  logic [4:0]      i_ra2,
  output logic [XLEN-1:0] o_rd1,
  output logic [XLEN-1:0] o_rd2,
  input  logic            i_we,
  input  logic [4:0]      i_wa,
  input  logic [XLEN-1:0] i_wd
);
  logic [XLEN-1:0] r_mem [NREGS];
  always_ff @(posedge clk)
    if (rst) r_mem <= '{default: '0};
    else if (i_we && i_wa != '0) r_mem[i_wa] <= i_wd;
  assign o_rd1 = (i_ra1 == '0) ? '0 : r_mem[i_ra1];
  assign o_rd2 = (i_ra2 == '0) ? '0 : r_mem[i_ra2];
endmodule

// File: rtl/decode_issue.sv
// decode_issue: RV32I decode/issue stage with scoreboard, writeback bypass and registered ALU bundle
//   i_in_valid/o_in_ready/i_in_instr : instruction handshake
//   o_out_*/i_out_ready              : registered ALU bundle handshake
//   i_wb_valid/i_wb_rd/i_wb_data     : writeback, clears busy and writes the register file
module decode_issue
  import rv_defs::*;
#(
  parameter int XLEN = rv_defs::XLEN,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [31:0]     i_in_instr,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [XLEN-1:0] o_out_a,
  output logic [XLEN-1:0] o_out_b,
  output logic [6:0]      o_out_opcode,
  output logic [2:0]      o_out_funct3,
  output logic [6:0]      o_out_funct7,
  output logic [4:0]      o_out_rd,
  output logic            o_out_illegal,
  input  logic            i_wb_valid,
  input  logic [4:0]      i_wb_rd,
  input  logic [XLEN-1:0] i_wb_data
);
  kind_e           w_kind;
  logic [4:0]      w_rs1, w_rs2, w_rd;
  logic            w_use1, w_use2, w_byp1, w_byp2, w_stall, w_acc;
  logic [XLEN-1:0] w_rf1, w_rf2, w_src1, w_src2, w_a, w_b;
  logic [NREGS-1:0] w_set, w_clr;
  logic [NREGS-1:0] r_busy;
  logic            r_valid, r_ill;
  logic [XLEN-1:0] r_a, r_b;
  logic [6:0]      r_op, r_f7;
  logic [2:0]      r_f3;
  logic [4:0]      r_rd;
  gpr_file #(.XLEN(XLEN), .NREGS(NREGS)) u_gpr (
    .clk   (clk),
    .rst   (rst),
    .i_ra1 (w_rs1),
    .i_ra2 (w_rs2),
    .o_rd1 (w_rf1),
    .o_rd2 (w_rf2),
    .i_we  (i_wb_valid),
    .i_wa  (i_wb_rd),
    .i_wd  (i_wb_data)
  );
  assign w_kind = kind_of(i_in_instr[6:0]);
  assign w_rs1 = i_in_instr[19:15];
  assign w_rs2 = i_in_instr[24:20];
  assign w_rd = (w_kind == K_ILL) ? 5'd0 : i_in_instr[11:7];
  assign w_use1 = (w_kind == K_R) || (w_kind == K_IMM);
  assign w_use2 = (w_kind == K_R);
  // a writeback landing this cycle both supplies the operand and resolves its hazard
  assign w_byp1 = i_wb_valid && i_wb_rd == w_rs1 && w_rs1 != '0;
  assign w_byp2 = i_wb_valid && i_wb_rd == w_rs2 && w_rs2 != '0;
  assign w_src1 = w_byp1 ? i_wb_data : w_rf1;
  assign w_src2 = w_byp2 ? i_wb_data : w_rf2;
  assign w_stall = (w_use1 && w_rs1 != '0 && r_busy[w_rs1] && !w_byp1) ||
                   (w_use2 && w_rs2 != '0 && r_busy[w_rs2] && !w_byp2) ||
                   (w_rd != '0 && r_busy[w_rd] && !(i_wb_valid && i_wb_rd == w_rd));
  assign o_in_ready = (!r_valid || i_out_ready) && !w_stall;
  assign w_acc = i_in_valid && o_in_ready;
  assign w_a = w_use1 ? w_src1 : '0;
  assign w_b = (w_kind == K_R) ? w_src2 :
               (w_kind == K_IMM) ? XLEN'(signed'(i_in_instr[31:20])) :
               (w_kind == K_LUI) ? XLEN'({i_in_instr[31:12], 12'b0}) : '0;
  // set is applied after clear so a same-index issue keeps the register busy
  assign w_clr = (i_wb_valid && i_wb_rd != '0) ? (NREGS'(1) << i_wb_rd) : '0;
  assign w_set = (w_acc && w_rd != '0) ? (NREGS'(1) << w_rd) : '0;
  always_ff @(posedge clk)
    if (rst) r_busy <= '0;
    else r_busy <= (r_busy & ~w_clr) | w_set;
  always_ff @(posedge clk)
    if (rst) begin
      r_valid <= 1'b0;
      r_a <= '0;
      r_b <= '0;
      r_op <= '0;
      r_f3 <= '0;
      r_f7 <= '0;
      r_rd <= '0;
      r_ill <= 1'b0;
    end else if (w_acc) begin
      r_valid <= 1'b1;
      r_a <= w_a;
      r_b <= w_b;
      r_op <= i_in_instr[6:0];
      r_f3 <= i_in_instr[14:12];
      r_f7 <= (w_kind == K_R) ? i_in_instr[31:25] : 7'd0;
      r_rd <= w_rd;
      r_ill <= (w_kind == K_ILL);
    end else if (i_out_ready) r_valid <= 1'b0;
  assign o_out_valid = r_valid;
  assign o_out_a = r_a;
  assign o_out_b = r_b;
  assign o_out_opcode = r_op;
  assign o_out_funct3 = r_f3;
  assign o_out_funct7 = r_f7;
  assign o_out_rd = r_rd;
  assign o_out_illegal = r_ill;
endmodule

// File: tb/tb_decode_issue.sv
// tb_decode_issue: directed table, corner sequences and random stimulus against a reference model
module tb_decode_issue;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_a, out_b;
  logic [6:0]  out_opcode, out_funct7;
  logic [2:0]  out_funct3;
  logic [4:0]  out_rd;
  logic        out_illegal;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  int errs = 0;
  int checks = 0;
  decode_issue dut (
    .clk           (clk),
    .rst           (rst),
    .i_in_valid    (in_valid),
    .o_in_ready    (in_ready),
    .i_in_instr    (in_instr),
    .o_out_valid   (out_valid),
    .i_out_ready   (out_ready),
    .o_out_a       (out_a),
    .o_out_b       (out_b),
    .o_out_opcode  (out_opcode),
    .o_out_funct3  (out_funct3),
    .o_out_funct7  (out_funct7),
    .o_out_rd      (out_rd),
    .o_out_illegal (out_illegal),
    .i_wb_valid    (wb_valid),
    .i_wb_rd       (wb_rd),
    .i_wb_data     (wb_data)
  );
  always #5 clk = ~clk;
  logic [31:0] m_rf [32];
  bit          m_busy [32];
  logic        m_valid, m_ill;
  logic [31:0] m_a, m_b;
  logic [6:0]  m_op, m_f7;
  logic [2:0]  m_f3;
  logic [4:0]  m_rd;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic bit hazard(input logic [4:0] x, input bit wv, input logic [4:0] wrd);
    return x != 0 && m_busy[x] && !(wv && wrd == x);
  endfunction
  function automatic logic [31:0] opnd(input logic [4:0] x, input bit wv, input logic [4:0] wrd,
                                       input logic [31:0] wd);
    return x == 0 ? 32'd0 : (wv && wrd == x) ? wd : m_rf[x];
  endfunction
  function automatic bit model_ready(input logic [31:0] ins, input bit ordy, input bit wv,
                                     input logic [4:0] wrd);
    logic [6:0] op;
    bit r, im, lu, h;
    op = ins[6:0];
    r = op == 7'h33;
    im = op == 7'h13;
    lu = op == 7'h37;
    h = ((r || im) && hazard(ins[19:15], wv, wrd)) || (r && hazard(ins[24:20], wv, wrd)) ||
        ((r || im || lu) && hazard(ins[11:7], wv, wrd));
    return (!m_valid || ordy) && !h;
  endfunction
  task automatic model_update(input bit rs, input bit v, input logic [31:0] ins, input bit ordy,
                              input bit wv, input logic [4:0] wrd, input logic [31:0] wd,
                              input bit rdy);
    logic [6:0] op;
    bit legal;
    if (rs) begin
      for (int i = 0; i < 32; i++) begin
        m_rf[i] = '0;
        m_busy[i] = 0;
      end
      {m_valid, m_a, m_b, m_op, m_f3, m_f7, m_rd, m_ill} = '0;
      return;
    end
    op = ins[6:0];
    legal = op == 7'h33 || op == 7'h13 || op == 7'h37;
    if (v && rdy) begin
      m_valid = 1;
      m_op = op;
      m_f3 = ins[14:12];
      m_f7 = op == 7'h33 ? ins[31:25] : 7'd0;
      m_rd = legal ? ins[11:7] : 5'd0;
      m_ill = !legal;
      m_a = (op == 7'h33 || op == 7'h13) ? opnd(ins[19:15], wv, wrd, wd) : 32'd0;
      m_b = op == 7'h33 ? opnd(ins[24:20], wv, wrd, wd) :
            op == 7'h13 ? {{20{ins[31]}}, ins[31:20]} :
            op == 7'h37 ? {ins[31:12], 12'd0} : 32'd0;
    end else if (ordy) m_valid = 0;
    if (wv && wrd != 0) begin
      m_rf[wrd] = wd;
      m_busy[wrd] = 0;
    end
    if (v && rdy && m_rd != 0) m_busy[m_rd] = 1;
  endtask
  task automatic step(input bit rs, input bit v, input logic [31:0] ins, input bit ordy,
                      input bit wv, input logic [4:0] wrd, input logic [31:0] wd, output bit got);
    bit er;
    rst = rs;
    in_valid = v;
    in_instr = ins;
    out_ready = ordy;
    wb_valid = wv;
    wb_rd = wrd;
    wb_data = wd;
    #1;
    got = in_ready;
    er = rs ? 1'b0 : model_ready(ins, ordy, wv, wrd);
    if (!rs) chk("in_ready", 128'(got), 128'(er));
    @(posedge clk);
    model_update(rs, v, ins, ordy, wv, wrd, wd, er);
    @(negedge clk);
    chk("bundle", {out_valid, out_a, out_b, out_opcode, out_funct3, out_funct7, out_rd, out_illegal},
        {m_valid, m_a, m_b, m_op, m_f3, m_f7, m_rd, m_ill});
  endtask
  function automatic logic [31:0] rnd_instr();
    logic [4:0] rd, rs1, rs2;
    logic [6:0] op;
    int k;
    rd = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    k = $urandom_range(0, 9);
    if (k < 4) return {7'($urandom), rs2, rs1, 3'($urandom), rd, 7'h33};
    if (k < 7) return {12'($urandom), rs1, 3'($urandom), rd, 7'h13};
    if (k < 9) return {20'($urandom), rd, 7'h37};
    op = 7'($urandom);
    if (op == 7'h33 || op == 7'h13 || op == 7'h37) op = 7'h7F;
    return {25'($urandom), op};
  endfunction
  typedef struct {
    logic [31:0] ins;
    logic [31:0] a, b;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic        ill;
  } vec_t;
  vec_t tbl [6];
  initial begin
    bit g;
    tbl[0] = '{32'h002081B3, 32'hFF00FF00, 32'h00FF00FF, 7'h33, 3'd0, 7'h00, 5'd3, 1'b0};
    tbl[1] = '{32'hFFF00213, 32'h00000000, 32'hFFFFFFFF, 7'h13, 3'd0, 7'h00, 5'd4, 1'b0};
    tbl[2] = '{32'hABCDE337, 32'h00000000, 32'hABCDE000, 7'h37, 3'd6, 7'h00, 5'd6, 1'b0};
    tbl[3] = '{32'h0000007F, 32'h00000000, 32'h00000000, 7'h7F, 3'd0, 7'h00, 5'd0, 1'b1};
    tbl[4] = '{32'h402083B3, 32'hFF00FF00, 32'h00FF00FF, 7'h33, 3'd0, 7'h20, 5'd7, 1'b0};
    tbl[5] = '{32'h7FF14413, 32'h00FF00FF, 32'h000007FF, 7'h13, 3'd4, 7'h00, 5'd8, 1'b0};
    step(1, 0, 0, 0, 0, 0, 0, g);
    step(1, 0, 0, 0, 0, 0, 0, g);
    chk("rst_valid", 128'(out_valid), 128'(0));
    step(0, 0, 0, 1, 1, 5'd1, 32'hFF00FF00, g);
    chk("rst_ready", 128'(g), 128'(1));
    step(0, 0, 0, 1, 1, 5'd2, 32'h00FF00FF, g);
    for (int i = 0; i < 6; i++) begin
      step(0, 1, tbl[i].ins, 1, 0, 0, 0, g);
      chk("tbl_ready", 128'(g), 128'(1));
      chk("tbl_bundle", {out_valid, out_a, out_b, out_opcode, out_funct3, out_funct7, out_rd, out_illegal},
          {1'b1, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].rd, tbl[i].ill});
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 32'h003182B3, 1, 0, 0, 0, g);
      chk("raw_stall", 128'(g), 128'(0));
    end
    step(0, 1, 32'h003182B3, 1, 1, 5'd3, 32'h12345678, g);
    chk("raw_bypass_ready", 128'(g), 128'(1));
    chk("raw_bypass_ab", {out_valid, out_a, out_b, out_rd}, {1'b1, 32'h12345678, 32'h12345678, 5'd5});
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 32'h00500493, 0, 0, 0, 0, g);
      chk("bp_ready", 128'(g), 128'(0));
      chk("bp_hold", {out_valid, out_a, out_b, out_rd}, {1'b1, 32'h12345678, 32'h12345678, 5'd5});
    end
    step(0, 1, 32'h00500493, 1, 0, 0, 0, g);
    chk("bp_release", {g, out_valid, out_a, out_b, out_rd}, {1'b1, 1'b1, 32'd0, 32'd5, 5'd9});
    step(0, 1, 32'h002081B3, 1, 0, 0, 0, g);
    chk("pre_rst_issue", {g, out_valid, out_rd}, {1'b1, 1'b1, 5'd3});
    step(1, 0, 0, 0, 1, 5'd3, 32'hDEADBEEF, g);
    chk("mid_rst_valid", 128'(out_valid), 128'(0));
    step(0, 1, 32'h003182B3, 1, 0, 0, 0, g);
    chk("post_rst_issue", {g, out_valid, out_a, out_b, out_rd}, {1'b1, 1'b1, 32'd0, 32'd0, 5'd5});
    for (int n = 0; n < 3000; n++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, rnd_instr(),
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)),
           $urandom, g);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
